fetch_unit: RTL

Parametrised instruction-fetch front end for the pipelined core. It owns the program counter and issues in-order requests to instruction memory over a valid/ready handshake. It buffers returned instructions with their PCs in a prefetch queue and applies conditional and unconditional branch redirects, with flush and discard of in-flight fetches. It replaces the single-register PC / PC+4 / branch-mux path of the single-cycle core and feeds the decode stage.

---
 rtl/fetch_pkg.sv | 33 +++
 rtl/fetch_queue.sv | 78 +++++++
 rtl/fetch_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the instruction-fetch front end: default widths,
// the branch-kind encoding and the branch target helper.
package fetch_pkg;

    localparam int unsigned ADDR_W_DEF  = 64;
    localparam int unsigned INSTR_W_DEF = 32;
    localparam int unsigned DEPTH_DEF   = 4;

    typedef enum logic {
        COND19   = 1'b0,
        UNCOND26 = 1'b1
    } br_kind_t;

    // Branch target = base + (sign-extended word offset << 2), mod 2^64.
    // Callers with narrower addresses keep the low bits. Carries only move
    // upward, so the low bits of the result are the narrow-width sum.
    function automatic logic [63:0] br_target(
        input logic        [63:0] base,
        input br_kind_t           kind,
        input logic signed [18:0] imm19,
        input logic signed [25:0] imm26
    );
        logic [63:0] off;
        if (kind == UNCOND26) begin
            off = {{36{imm26[25]}}, imm26, 2'b00};
        end else begin
            off = {{43{imm19[18]}}, imm19, 2'b00};
        end
        return base + off;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue
// Synchronous FIFO with a single-cycle flush. Used as the prefetch queue,
// carrying {pc, instr} per entry.
// Ports:
//   clk, reset (async, active-low)
//   push / push_data : write at tail
//   pop              : remove head
//   flush            : empty the queue (takes priority over push/pop)
//   head_data        : current head entry (valid when count != 0)
//   count            : occupancy, 0..DEPTH
module fetch_queue #(
    parameter int unsigned W     = 96,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [W-1:0]                 head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok;
    logic             push_ok;

    // Guard against pops on empty and pushes on full so misuse cannot
    // corrupt the count.
    assign pop_ok  = pop && (count_q != '0);
    assign push_ok = push && ((count_q != CNT_W'(DEPTH)) || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; entries are only read when count says so.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch front end. Owns the PC, issues in-order requests to
// instruction memory, buffers returned instructions with their PCs in a
// prefetch queue and applies branch redirects (flushing the queue and
// discarding responses still in flight).
// Ports:
//   clk, reset (async, active-low)
//   imem_req_valid/ready/addr : request channel (addr = current PC)
//   imem_rsp_valid/data       : in-order response strobe, never stalled
//   redirect_valid/uncond/base, imm19, imm26 : taken-branch redirect
//   out_valid/ready/instr/pc  : head of the prefetch queue to decode
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter int unsigned       INSTR_W  = INSTR_W_DEF,
    parameter int unsigned       DEPTH    = DEPTH_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      imem_req_valid,
    input  logic                      imem_req_ready,
    output logic [ADDR_W-1:0]         imem_req_addr,
    input  logic                      imem_rsp_valid,
    input  logic [INSTR_W-1:0]        imem_rsp_data,
    input  logic                      redirect_valid,
    input  logic                      redirect_uncond,
    input  logic [ADDR_W-1:0]         redirect_base,
    input  logic signed [18:0]        imm19,
    input  logic signed [25:0]        imm26,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [INSTR_W-1:0]        out_instr,
    output logic [ADDR_W-1:0]         out_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned QW    = ADDR_W + INSTR_W;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [CNT_W-1:0]  drop_q, drop_d;

    logic [CNT_W-1:0]  count;
    logic [QW-1:0]     head_data;
    logic [CNT_W:0]    in_use;
    logic              credit;
    logic              req_fire;
    logic              rsp_keep;
    logic              pop;
    logic [63:0]       target_full;
    logic [ADDR_W-1:0] target;

    assign target_full = br_target(64'(redirect_base),
                                   br_kind_t'(redirect_uncond), imm19, imm26);
    assign target      = target_full[ADDR_W-1:0];

    // Queue slots plus in-flight requests never exceed DEPTH, so every
    // response has a slot waiting for it and the queue cannot overflow.
    assign in_use = {1'b0, count} + {1'b0, outst_q};
    assign credit = in_use < (CNT_W + 1)'(DEPTH);

    // reset gates the request so nothing is offered while held in reset;
    // the first request goes out as soon as reset is released.
    assign imem_req_valid = reset && credit && !redirect_valid;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_keep  = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
    assign out_valid = (count != '0) && !redirect_valid;
    assign pop       = out_valid && out_ready;

    always_comb begin
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        outst_d  = outst_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
        drop_d   = drop_q;
        if (redirect_valid) begin
            pc_d     = target;
            rsp_pc_d = target;
            // Everything still in flight after this edge belongs to the
            // old path, including anything an earlier redirect was
            // already discarding.
            drop_d   = outst_q - CNT_W'(imem_rsp_valid);
        end else begin
            if (req_fire) pc_d     = pc_q + ADDR_W'(4);
            if (rsp_keep) rsp_pc_d = rsp_pc_q + ADDR_W'(4);
            if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            outst_q  <= '0;
            drop_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
        end
    end

    fetch_queue #(
        .W     (QW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (rsp_keep),
        .push_data ({rsp_pc_q, imem_rsp_data}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_data (head_data),
        .count     (count)
    );

    assign out_pc    = head_data[QW-1:INSTR_W];
    assign out_instr = head_data[INSTR_W-1:0];

endmodule
